transmisor_hamming: RTL

TRANSMISOR_HAMMING -- requirements
Module: transmisor_hamming

---
 rtl/hamming_pkg.sv | 55 +++++
 rtl/codificador_hamming_8_4.sv | 20 ++
 rtl/transmisor_hamming.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared definitions for the Hamming(8,4) SECDED transmitter
//                and its matching decoder: FSM state type, codeword bit
//                positions, encoder and syndrome helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Serial framing FSM states
    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        INICIO = 2'd1,
        DATOS  = 2'd2,
        PARADA = 2'd3
    } estado_t;

    // Bit positions inside the 8-bit codeword
    localparam logic [2:0] c_POS_P1 = 3'd0;
    localparam logic [2:0] c_POS_P2 = 3'd1;
    localparam logic [2:0] c_POS_D1 = 3'd2;
    localparam logic [2:0] c_POS_P3 = 3'd3;
    localparam logic [2:0] c_POS_D2 = 3'd4;
    localparam logic [2:0] c_POS_D3 = 3'd5;
    localparam logic [2:0] c_POS_D4 = 3'd6;
    localparam logic [2:0] c_POS_PT = 3'd7;

    // Builds the SECDED codeword; bit 7 makes the parity of all 8 bits even
    function automatic logic [7:0] calc_codigo(input logic [3:0] dato);
        logic [7:0] c;
        c           = 8'h00;
        c[c_POS_D1] = dato[0];
        c[c_POS_D2] = dato[1];
        c[c_POS_D3] = dato[2];
        c[c_POS_D4] = dato[3];
        c[c_POS_P1] = dato[0] ^ dato[1] ^ dato[3];
        c[c_POS_P2] = dato[0] ^ dato[2] ^ dato[3];
        c[c_POS_P3] = dato[1] ^ dato[2] ^ dato[3];
        c[c_POS_PT] = ^c[6:0];
        return c;
    endfunction

    // Hamming syndrome of a received word: the 1-based position of a single
    // flipped bit among bits [6:0], zero when the inner code is consistent
    function automatic logic [2:0] calc_sindrome(input logic [7:0] palabra);
        logic [2:0] s;
        s[0] = palabra[c_POS_P1] ^ palabra[c_POS_D1] ^ palabra[c_POS_D2] ^ palabra[c_POS_D4];
        s[1] = palabra[c_POS_P2] ^ palabra[c_POS_D1] ^ palabra[c_POS_D3] ^ palabra[c_POS_D4];
        s[2] = palabra[c_POS_P3] ^ palabra[c_POS_D2] ^ palabra[c_POS_D3] ^ palabra[c_POS_D4];
        return s;
    endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/codificador_hamming_8_4.sv
`default_nettype none
// ============================================================================
//  Module      : codificador_hamming_8_4
//  Description : Purely combinational Hamming(8,4) SECDED encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module codificador_hamming_8_4
    import hamming_pkg::*;
(
    input  logic [3:0] dato,
    output logic [7:0] codigo
);

    // Codeword straight from the shared package encoder
    always_comb begin
        codigo = calc_codigo(dato);
    end

endmodule : codificador_hamming_8_4
`default_nettype wire

// File: rtl/transmisor_hamming.sv
`default_nettype none
// ============================================================================
//  Module      : transmisor_hamming
//  Description : Accepts a 4-bit nibble with a valid/ready handshake, encodes
//                it as a Hamming(8,4) SECDED codeword and sends it on a serial
//                line: start bit 0, 8 codeword bits LSB first, stop bit 1,
//                each bit lasting CICLOS_POR_BIT clock cycles.
//                Optional macro INYECCION_ERROR_EN adds port mascara_error;
//                the serialised word is then the codeword XOR the mask
//                sampled at transfer, while palabra stays the clean codeword.
//  Revision    : 1.0 - initial release
// ============================================================================
module transmisor_hamming
    import hamming_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic       reloj,
    input  logic       reset_n,
    input  logic [3:0] dato,
    input  logic       valido,
`ifdef INYECCION_ERROR_EN
    input  logic [7:0] mascara_error,
`endif
    output logic       listo,
    output logic [7:0] palabra,
    output logic       tx,
    output logic       ocupado,
    output logic       fin
);

    // Last value of the per-bit cycle counter; the counter never goes past it
    localparam logic [7:0] c_CNT_MAX    = 8'(CICLOS_POR_BIT - 1);
    localparam logic [2:0] c_ULTIMO_BIT = 3'd7;

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_sig;
    logic [2:0] r_bit;
    logic [2:0] w_bit_sig;
    logic [7:0] r_desp;
    logic [7:0] w_desp_sig;
    logic [7:0] r_palabra;
    logic       r_tx;
    logic       r_listo;
    logic       r_ocupado;
    logic       r_fin;
    logic       w_tx_sig;
    logic       w_listo_sig;
    logic       w_ocupado_sig;
    logic       w_fin_sig;
    logic       w_carga;
    logic [7:0] w_codigo;
    logic [7:0] w_mascara;
    logic       w_transferencia;
    logic       w_fin_periodo;

    codificador_hamming_8_4 u_codificador (
        .dato   (dato),
        .codigo (w_codigo)
    );

`ifdef INYECCION_ERROR_EN
    assign w_mascara = mascara_error;
`else
    assign w_mascara = 8'h00;
`endif

    // listo is registered and is high only in REPOSO, so it gates the handshake
    assign w_transferencia = valido && r_listo;
    assign w_fin_periodo   = (r_cnt == c_CNT_MAX);

    // Next-state, counters, shift register and next values of the registered outputs
    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        w_bit_sig    = r_bit;
        w_desp_sig   = r_desp;
        w_fin_sig    = 1'b0;
        w_carga      = 1'b0;

        case (r_estado)
            REPOSO: begin
                if (w_transferencia) begin
                    w_carga      = 1'b1;
                    w_estado_sig = INICIO;
                    w_cnt_sig    = 8'd0;
                    w_bit_sig    = 3'd0;
                    w_desp_sig   = w_codigo ^ w_mascara;
                end
            end
            INICIO: begin
                if (w_fin_periodo) begin
                    w_cnt_sig    = 8'd0;
                    w_estado_sig = DATOS;
                end else begin
                    w_cnt_sig = r_cnt + 8'd1;
                end
            end
            DATOS: begin
                if (w_fin_periodo) begin
                    w_cnt_sig = 8'd0;
                    if (r_bit == c_ULTIMO_BIT) begin
                        w_estado_sig = PARADA;
                    end else begin
                        w_bit_sig  = r_bit + 3'd1;
                        w_desp_sig = {1'b0, r_desp[7:1]};
                    end
                end else begin
                    w_cnt_sig = r_cnt + 8'd1;
                end
            end
            PARADA: begin
                if (w_fin_periodo) begin
                    w_cnt_sig    = 8'd0;
                    w_estado_sig = REPOSO;
                    w_fin_sig    = 1'b1;
                end else begin
                    w_cnt_sig = r_cnt + 8'd1;
                end
            end
            default: begin
                w_estado_sig = REPOSO;
                w_cnt_sig    = 8'd0;
                w_bit_sig    = 3'd0;
            end
        endcase

        // Outputs follow the state being entered so they can be registered
        case (w_estado_sig)
            INICIO:  w_tx_sig = 1'b0;
            DATOS:   w_tx_sig = w_desp_sig[0];
            default: w_tx_sig = 1'b1;
        endcase
        w_listo_sig   = (w_estado_sig == REPOSO);
        w_ocupado_sig = (w_estado_sig != REPOSO);
    end

    // State, counters and registered outputs; reset aborts any frame at once
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= REPOSO;
            r_cnt     <= 8'd0;
            r_bit     <= 3'd0;
            r_desp    <= 8'h00;
            r_palabra <= 8'h00;
            r_tx      <= 1'b1;
            r_listo   <= 1'b1;
            r_ocupado <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_cnt     <= w_cnt_sig;
            r_bit     <= w_bit_sig;
            r_desp    <= w_desp_sig;
            r_tx      <= w_tx_sig;
            r_listo   <= w_listo_sig;
            r_ocupado <= w_ocupado_sig;
            r_fin     <= w_fin_sig;
            if (w_carga) begin
                r_palabra <= w_codigo;
            end
        end
    end

    assign listo   = r_listo;
    assign palabra = r_palabra;
    assign tx      = r_tx;
    assign ocupado = r_ocupado;
    assign fin     = r_fin;

endmodule : transmisor_hamming
`default_nettype wire
